// File: rtl/axis_fixed_divider_if.sv
// Operand/result stream bundle between the inverse engine (master) and the
// fixed-point divider (slave). The optional divide-by-zero flag
// m_axis_dout_tuser exists only when DIVIDER_DBZ_FLAG_EN is defined.
interface axis_fixed_divider_if #(
  parameter int DIVIDEND_TDATA_WIDTH = 32,
  parameter int DIVISOR_TDATA_WIDTH  = 32,
  parameter int DIVOUT_TDATA_WIDTH   = 48
);
  logic [DIVIDEND_TDATA_WIDTH-1:0] s_axis_dividend_tdata;
  logic                            s_axis_dividend_tvalid;
  logic                            s_axis_dividend_tready;
  logic [DIVISOR_TDATA_WIDTH-1:0]  s_axis_divisor_tdata;
  logic                            s_axis_divisor_tvalid;
  logic                            s_axis_divisor_tready;
  logic [DIVOUT_TDATA_WIDTH-1:0]   m_axis_dout_tdata;
  logic                            m_axis_dout_tvalid;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic                            m_axis_dout_tuser;
`endif

  modport master (
    output s_axis_dividend_tdata,
    output s_axis_dividend_tvalid,
    input  s_axis_dividend_tready,
    output s_axis_divisor_tdata,
    output s_axis_divisor_tvalid,
    input  s_axis_divisor_tready,
    input  m_axis_dout_tdata,
    input  m_axis_dout_tvalid
`ifdef DIVIDER_DBZ_FLAG_EN
    , input m_axis_dout_tuser
`endif
  );

  modport slave (
    input  s_axis_dividend_tdata,
    input  s_axis_dividend_tvalid,
    output s_axis_dividend_tready,
    input  s_axis_divisor_tdata,
    input  s_axis_divisor_tvalid,
    output s_axis_divisor_tready,
    output m_axis_dout_tdata,
    output m_axis_dout_tvalid
`ifdef DIVIDER_DBZ_FLAG_EN
    , output m_axis_dout_tuser
`endif
  );
endinterface

// File: rtl/axis_fixed_divider.sv
// Sequential signed fixed-point divider, radix-2 restoring, one quotient bit
// per cycle, one operation in flight. Output word is {quotient, frac} where
// frac is a signed field with DIVOUT_F_WIDTH-1 fraction bits.
// Optional feature: define DIVIDER_DBZ_FLAG_EN to add m_axis_dout_tuser,
// set when the result came from a zero divisor.
module axis_fixed_divider #(
  parameter int DIVIDEND_TDATA_WIDTH = 32,
  parameter int DIVISOR_TDATA_WIDTH  = 32,
  parameter int DIVOUT_F_WIDTH       = 16,
  parameter int DIVOUT_TDATA_WIDTH   = 48
) (
  input logic           clk,
  input logic           rst_n,
  axis_fixed_divider_if.slave div_if
);
  localparam int QW    = DIVIDEND_TDATA_WIDTH;
  localparam int DW    = DIVISOR_TDATA_WIDTH;
  localparam int FW    = DIVOUT_F_WIDTH;
  localparam int NW    = QW + FW - 1;      // numerator bits = iteration count
  localparam int CNT_W = 6;

  localparam logic [QW-1:0] Q_MAX = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] Q_MIN = {1'b1, {(QW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t                        state_q;
  logic [QW-1:0]                 dvd_q;
  logic [DW-1:0]                 dvs_q;
  logic [NW-1:0]                 num_q;    // shifts numerator out, quotient in
  logic [DW:0]                   den_q;
  logic [DW-1:0]                 rem_q;
  logic [CNT_W-1:0]              cnt_q;
  logic                          neg_q;
  logic                          dvd_neg_q;
  logic                          dbz_q;
  logic                          ovf_q;
  logic [DIVOUT_TDATA_WIDTH-1:0] tdata_q;
  logic                          tvalid_q;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic                          tuser_q;
`endif

  logic          accept;
  logic [QW-1:0] dvd_abs;
  logic [DW:0]   dvs_ext;
  logic [DW:0]   dvs_abs;
  logic [DW:0]   trial;
  logic          ge;
  logic [QW-1:0] int_mag;
  logic [FW-1:0] frac_mag;
  logic [QW-1:0] quot_d;
  logic [FW-1:0] frac_d;

  assign accept = (state_q == IDLE) && div_if.s_axis_dividend_tvalid
                  && div_if.s_axis_divisor_tvalid;

  // |-2^(QW-1)| = 2^(QW-1) still fits QW bits when read as unsigned.
  assign dvd_abs = dvd_q[QW-1] ? (-dvd_q) : dvd_q;
  // Divisor magnitude taken at DW+1 bits so it is never truncated.
  assign dvs_ext = {dvs_q[DW-1], dvs_q};
  assign dvs_abs = dvs_q[DW-1] ? (-dvs_ext) : dvs_ext;

  // Partial remainder is always below |divisor|, so DW bits hold it and the
  // shifted trial value needs only one more.
  assign trial = {rem_q, num_q[NW-1]};
  assign ge    = (trial >= den_q);

  assign int_mag  = num_q[NW-1:FW-1];
  assign frac_mag = {1'b0, num_q[FW-2:0]};

  // Final result: saturation cases first, otherwise apply the result sign.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    quot_d = '0;
    frac_d = '0;
    if (dbz_q) begin
      quot_d = dvd_neg_q ? Q_MIN : Q_MAX;
    end else if (ovf_q) begin
      quot_d = Q_MAX;
    end else begin
      quot_d = neg_q ? (-int_mag)  : int_mag;
      frac_d = neg_q ? (-frac_mag) : frac_mag;
    end
  end

  // Control FSM and datapath: capture, prepare magnitudes, iterate, fix sign.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: working registers are reset together with the FSM so an operation aborted by reset leaves no stale state behind.
    if (!rst_n) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      num_q     <= '0;
      den_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
`ifdef DIVIDER_DBZ_FLAG_EN
      tuser_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments: every register sees the pre-edge values of the others.
      tvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            dvd_q   <= div_if.s_axis_dividend_tdata;
            dvs_q   <= div_if.s_axis_divisor_tdata;
            state_q <= PREP;
          end
        end
        PREP: begin
          num_q     <= {dvd_abs, {(FW-1){1'b0}}};
          den_q     <= dvs_abs;
          rem_q     <= '0;
          cnt_q     <= '0;
          neg_q     <= dvd_q[QW-1] ^ dvs_q[DW-1];
          dvd_neg_q <= dvd_q[QW-1];
          dbz_q     <= (dvs_q == '0);
          ovf_q     <= (dvd_q == Q_MIN) && (dvs_q == '1);
          state_q   <= ITER;
        end
        ITER: begin
          rem_q <= ge ? DW'(trial - den_q) : trial[DW-1:0];
          num_q <= {num_q[NW-2:0], ge};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NW - 1)) state_q <= FIX;
        end
        FIX: begin
          tdata_q  <= {quot_d, frac_d};
          tvalid_q <= 1'b1;
`ifdef DIVIDER_DBZ_FLAG_EN
          tuser_q  <= dbz_q;
`endif
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_if.s_axis_dividend_tready = (state_q == IDLE);
  assign div_if.s_axis_divisor_tready  = (state_q == IDLE);
  assign div_if.m_axis_dout_tdata      = tdata_q;
  assign div_if.m_axis_dout_tvalid     = tvalid_q;
`ifdef DIVIDER_DBZ_FLAG_EN
  assign div_if.m_axis_dout_tuser      = tuser_q;
`endif
endmodule

// File: tb/tb_axis_fixed_divider.sv
// Directed bench for axis_fixed_divider with a result scoreboard. Expected
// words come from literal constants or an integer reference model.
module tb_axis_fixed_divider;
  localparam int QW  = 32;
  localparam int DW  = 32;
  localparam int FW  = 16;
  localparam int OW  = 48;
  localparam int LAT = QW + FW + 1;

  typedef struct {
    logic [OW-1:0] tdata;
    logic          tuser;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  axis_fixed_divider_if #(
    .DIVIDEND_TDATA_WIDTH(QW),
    .DIVISOR_TDATA_WIDTH (DW),
    .DIVOUT_TDATA_WIDTH  (OW)
  ) dif ();

  axis_fixed_divider #(
    .DIVIDEND_TDATA_WIDTH(QW),
    .DIVISOR_TDATA_WIDTH (DW),
    .DIVOUT_F_WIDTH      (FW),
    .DIVOUT_TDATA_WIDTH  (OW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .div_if(dif)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating integer quotient plus floor-scaled remainder.
  function automatic exp_t model(input logic signed [31:0] a, input logic signed [31:0] b);
    exp_t   e;
    longint la, lb, lq, ua, ub, r, fm, lf;
    la = longint'(a);
    lb = longint'(b);
    e.tuser = 1'b0;
    if (lb == 0) begin
      e.tdata = (la >= 0) ? 48'h7FFF_FFFF_0000 : 48'h8000_0000_0000;
      e.tuser = 1'b1;
    end else if (la == -64'sd2147483648 && lb == -1) begin
      e.tdata = 48'h7FFF_FFFF_0000;
    end else begin
      lq = la / lb;
      ua = (la < 0) ? -la : la;
      ub = (lb < 0) ? -lb : lb;
      r  = ua % ub;
      fm = (r * 32768) / ub;
      lf = ((la < 0) != (lb < 0)) ? -fm : fm;
      e.tdata = {lq[31:0], lf[15:0]};
    end
    return e;
  endfunction

  task automatic push(input logic [OW-1:0] d, input logic u);
    exp_t e;
    e.tdata = d;
    e.tuser = u;
    sb.push_back(e);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dif.s_axis_dividend_tdata  = a;
    dif.s_axis_divisor_tdata   = b;
    dif.s_axis_dividend_tvalid = 1'b1;
    dif.s_axis_divisor_tvalid  = 1'b1;
    @(negedge clk);
    dif.s_axis_dividend_tvalid = 1'b0;
    dif.s_axis_divisor_tvalid  = 1'b0;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_tdata"}, 64'(dif.m_axis_dout_tdata), 64'(e.tdata));
`ifdef DIVIDER_DBZ_FLAG_EN
      check({tag, "_tuser"}, 64'(dif.m_axis_dout_tuser), 64'(e.tuser));
`endif
    end
  endtask

  // Called on the falling edge right after the accept edge.
  task automatic wait_result(input string tag, input int exp_lat);
    int n = 0;
    int busy_bad = 0;
    while (dif.m_axis_dout_tvalid !== 1'b1 && n < 200) begin
      if (dif.s_axis_dividend_tready !== 1'b0 || dif.s_axis_divisor_tready !== 1'b0)
        busy_bad++;
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 64'(dif.m_axis_dout_tvalid), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_busy_tready"}, 64'(busy_bad), 64'd0);
    check({tag, "_tready_back"}, 64'(dif.s_axis_dividend_tready & dif.s_axis_divisor_tready), 64'd1);
    if (dif.m_axis_dout_tvalid === 1'b1) check_out(tag);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(dif.m_axis_dout_tvalid), 64'd0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (dif.m_axis_dout_tvalid !== 1'b0) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [OW-1:0] d, input logic u);
    push(d, u);
    send(a, b);
    wait_result(tag, LAT);
  endtask

  initial begin
    exp_t e;
    int   low_cnt;
    logic signed [31:0] ra, rb;

    rst_n = 1'b0;
    dif.s_axis_dividend_tdata  = '0;
    dif.s_axis_divisor_tdata   = '0;
    dif.s_axis_dividend_tvalid = 1'b0;
    dif.s_axis_divisor_tvalid  = 1'b0;
    #23;
    check("rst_tvalid", 64'(dif.m_axis_dout_tvalid), 64'd0);
    check("rst_tdata", 64'(dif.m_axis_dout_tdata), 64'd0);
    check("rst_tready", 64'(dif.s_axis_dividend_tready & dif.s_axis_divisor_tready), 64'd1);
`ifdef DIVIDER_DBZ_FLAG_EN
    check("rst_tuser", 64'(dif.m_axis_dout_tuser), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run("div_1_4",      32'd1,          32'd4,          48'h0000_0000_2000, 1'b0);
    run("div_100_7",    32'd100,        32'd7,          48'h0000_000E_2492, 1'b0);
    run("div_m100_7",   -32'sd100,      32'd7,          48'hFFFF_FFF2_DB6E, 1'b0);
    run("div_m3_4",     -32'sd3,        32'd4,          48'h0000_0000_A000, 1'b0);
    run("dbz_pos",      32'd5,          32'd0,          48'h7FFF_FFFF_0000, 1'b1);
    run("dbz_neg",      -32'sd5,        32'd0,          48'h8000_0000_0000, 1'b1);
    run("ovf",          32'h8000_0000,  32'hFFFF_FFFF,  48'h7FFF_FFFF_0000, 1'b0);
    run("min_by_1",     32'h8000_0000,  32'd1,          48'h8000_0000_0000, 1'b0);
    run("min_by_min",   32'h8000_0000,  32'h8000_0000,  48'h0000_0001_0000, 1'b0);

    e = model(32'sh4000_0000, 32'sh7FFF_FFFF);
    run("big_divisor", 32'h4000_0000, 32'h7FFF_FFFF, e.tdata, e.tuser);
    for (int i = 0; i < 4; i++) begin
      ra = $signed($urandom);
      rb = $signed($urandom_range(1, 100000));
      if ($urandom_range(0, 1) == 1) rb = -rb;
      e = model(ra, rb);
      run($sformatf("rand%0d", i), ra, rb, e.tdata, e.tuser);
    end

    // Operands offered while busy must be ignored.
    push(48'h0000_0000_2000, 1'b0);
    send(32'd1, 32'd4);
    repeat (10) @(negedge clk);
    dif.s_axis_dividend_tdata  = 32'd9;
    dif.s_axis_divisor_tdata   = 32'd3;
    dif.s_axis_dividend_tvalid = 1'b1;
    dif.s_axis_divisor_tvalid  = 1'b1;
    repeat (2) @(negedge clk);
    dif.s_axis_dividend_tvalid = 1'b0;
    dif.s_axis_divisor_tvalid  = 1'b0;
    wait_result("busy_ignore", LAT - 12);
    expect_quiet("busy_no_extra", 60);
    check("busy_sb_drained", 64'(sb.size()), 64'd0);

    // Dividend valid alone is not an accept.
    low_cnt = 0;
    @(negedge clk);
    dif.s_axis_dividend_tdata  = 32'd9;
    dif.s_axis_divisor_tdata   = 32'd3;
    dif.s_axis_dividend_tvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (dif.s_axis_dividend_tready !== 1'b1) low_cnt++;
    end
    dif.s_axis_dividend_tvalid = 1'b0;
    check("half_valid_tready", 64'(low_cnt), 64'd0);
    expect_quiet("half_valid_quiet", 60);

    // Back-to-back: second pair waiting when the first result appears.
    push(48'h0000_000E_2492, 1'b0);
    push(48'hFFFF_FFF2_DB6E, 1'b0);
    send(32'd100, 32'd7);
    repeat (LAT - 1) @(negedge clk);
    dif.s_axis_dividend_tdata  = -32'sd100;
    dif.s_axis_divisor_tdata   = 32'd7;
    dif.s_axis_dividend_tvalid = 1'b1;
    dif.s_axis_divisor_tvalid  = 1'b1;
    @(negedge clk);
    check("b2b_first_tvalid", 64'(dif.m_axis_dout_tvalid), 64'd1);
    check_out("b2b_first");
    @(negedge clk);
    check("b2b_first_pulse", 64'(dif.m_axis_dout_tvalid), 64'd0);
    check("b2b_second_taken", 64'(dif.s_axis_dividend_tready), 64'd0);
    dif.s_axis_dividend_tvalid = 1'b0;
    dif.s_axis_divisor_tvalid  = 1'b0;
    wait_result("b2b_second", LAT);

    // Reset in the middle of an operation.
    send(32'd1, 32'd4);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 64'(dif.m_axis_dout_tvalid), 64'd0);
    check("midrst_tdata", 64'(dif.m_axis_dout_tdata), 64'd0);
    check("midrst_tready", 64'(dif.s_axis_dividend_tready & dif.s_axis_divisor_tready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("midrst_no_stale", 70);
    check("midrst_tdata_hold", 64'(dif.m_axis_dout_tdata), 64'd0);
    run("post_rst_100_7", 32'd100, 32'd7, 48'h0000_000E_2492, 1'b0);

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
